// File: rtl/oam_dma_controller.sv
`default_nettype none
// ============================================================================
// Module      : oam_dma_controller
// Description : Sprite-memory DMA engine. A CPU write to 16'h4014 halts the
//               CPU and copies one 256-byte page to the OAM data port 16'h2004.
// Revision    : 1.0 - initial release
// ============================================================================
module oam_dma_controller (
    input  logic        clk_ph2,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_rw,
    input  logic [7:0]  mem_din,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_dout,
    output logic        bus_rw,
    output logic        cpu_rdy,
    output logic        dma_busy
);

    localparam logic [15:0] C_DMA_REG_ADDR  = 16'h4014;
    localparam logic [15:0] C_OAM_DATA_ADDR = 16'h2004;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_page;
    logic [7:0] r_index;
    logic [7:0] r_data;
    logic       r_parity;
    logic       w_trigger;

    assign w_trigger = (r_state == IDLE) && !cpu_rw && (cpu_addr == C_DMA_REG_ADDR);

    always_ff @(posedge clk_ph2 or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        bus_addr     = cpu_addr;
        bus_dout     = cpu_dout;
        bus_rw       = cpu_rw;
        cpu_rdy      = 1'b0;
        case (r_state)
            IDLE: begin
                cpu_rdy = 1'b1;
                if (w_trigger) begin
                    w_state_next = HALT;
                end
            end
            HALT: begin
                w_state_next = r_parity ? ALIGN : READ;
            end
            ALIGN: begin
                // Dummy read cycle on the CPU's own address to reach even parity
                bus_rw       = 1'b1;
                w_state_next = READ;
            end
            READ: begin
                bus_addr     = {r_page, r_index};
                bus_rw       = 1'b1;
                w_state_next = WRITE;
            end
            WRITE: begin
                bus_addr     = C_OAM_DATA_ADDR;
                bus_rw       = 1'b0;
                bus_dout     = r_data;
                w_state_next = (r_index == 8'hFF) ? IDLE : READ;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign dma_busy = ~cpu_rdy;

    always_ff @(posedge clk_ph2 or negedge rst) begin
        if (!rst) begin
            r_page   <= 8'h00;
            r_index  <= 8'h00;
            r_data   <= 8'h00;
            r_parity <= 1'b0;
        end else begin
            r_parity <= ~r_parity;
            if (w_trigger) begin
                r_page  <= cpu_dout;
                r_index <= 8'h00;
            end
            if (r_state == READ) begin
                r_data <= mem_din;
            end
            if (r_state == WRITE) begin
                r_index <= r_index + 8'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/oam_dma_controller.md
OAM_DMA_CONTROLLER -- requirements
Module: oam_dma_controller

Interface
REQ-001 The block SHALL have one clock and asynchronous active-low reset; clock and reset SHALL be named clk_ph2 and rst.
REQ-002 The block SHALL expose these ports, listed as name, direction, width, meaning:
- clk_ph2   in   1   CPU phase-2 clock; all state updates on its rising edge
- rst       in   1   asynchronous active-low reset
- cpu_addr  in   16  CPU core address bus
- cpu_dout  in   8   CPU core write data
- cpu_rw    in   1   CPU core direction: 1 = read, 0 = write
- mem_din   in   8   data returned by system bus on reads
- bus_addr  out  16  system bus address
- bus_dout  out  8   system bus write data
- bus_rw    out  1   system bus direction: 1 = read, 0 = write
- cpu_rdy   out  1   CPU stall control: 1 = run, 0 = halt
- dma_busy  out  1   1 while a transfer is in progress

Function
REQ-003 The block SHALL implement a state machine with states IDLE, HALT, ALIGN, READ and WRITE.
REQ-004 The block SHALL hold an 8-bit page register, an 8-bit index counter, an 8-bit data latch and a 1-bit parity flag.
REQ-005 The parity flag SHALL toggle on every clock edge, in every state.
REQ-006 In IDLE and HALT, bus_addr, bus_dout and bus_rw SHALL equal cpu_addr, cpu_dout and cpu_rw combinationally.
REQ-007 cpu_rdy SHALL be 1 only in IDLE; dma_busy SHALL be the inverse of cpu_rdy.
REQ-008 Trigger: in IDLE, with cpu_rw=0 and cpu_addr=16'h4014 at a clock edge, the block SHALL latch page<=cpu_dout, clear the index and go to HALT.
REQ-009 HALT SHALL last exactly one cycle.
- Exit to ALIGN if parity=1 at that edge; otherwise exit to READ.
REQ-010 ALIGN SHALL last exactly one cycle, then go to READ.
- During ALIGN, bus_addr SHALL equal cpu_addr and bus_rw SHALL be 1 (dummy read, no write).
REQ-011 READ SHALL drive bus_addr={page,index} and bus_rw=1.
- At the edge, the data latch SHALL capture mem_din, then go to WRITE.
REQ-012 WRITE SHALL drive bus_addr=16'h2004, bus_rw=0 and bus_dout=data latch.
- At the edge, the index SHALL increment by 1 (mod 256).
- Go to IDLE if the index was 8'hFF before the increment; otherwise go to READ.
REQ-013 Exactly 256 READ/WRITE pairs SHALL occur per trigger, covering source offsets 00..FF in ascending order.
- The page register SHALL NOT change during a transfer.
REQ-014 Latency from the trigger edge to cpu_rdy=1 SHALL be 513 cycles (parity 0 at HALT exit) or 514 cycles (parity 1).
REQ-015 Writes to 16'h4014 while not in IDLE SHALL be ignored.
- bus_dout SHALL be don't-care when bus_rw=1.
REQ-016 A trigger SHALL be accepted on the first edge after returning to IDLE if the trigger condition holds there.

Reset
REQ-017 While rst=0, the block SHALL force IDLE, page=0, index=0, data latch=0 and parity=0 asynchronously.
- Outputs during reset: cpu_rdy=1, dma_busy=0, bus_* = CPU passthrough.
REQ-018 Reset asserted mid-transfer SHALL abort the transfer immediately, with no further bus write to 16'h2004; the block SHALL restart cleanly after release.

Verification
REQ-019 Trigger when parity=0 at HALT exit, page=8'h02, memory[0x0200+i]=i^8'h5A:
- 256 writes to 16'h2004 carrying data 5A,5B,... in order.
- cpu_rdy low for exactly 513 cycles.
REQ-020 Same stimulus, one-cycle-later trigger so parity=1:
- One ALIGN cycle with no write.
- cpu_rdy low for exactly 514 cycles; data identical to REQ-019.
REQ-021 Write 8'h07 to 16'h4014 during transfer (forced cpu_* inputs):
- Page stays 8'h02.
- Transfer length unchanged.
REQ-022 Assert rst at READ of index 8'h80:
- Immediate IDLE and cpu_rdy=1.
- No write to 16'h2004 after reset.
- A subsequent trigger with page 8'h03 copies 256 bytes from 0x0300.
REQ-023 CPU write to 16'h4013 or a CPU read of 16'h4014:
- No transfer; dma_busy stays 0.
- bus_* mirrors cpu_* every cycle.
REQ-024 Back-to-back triggers (second issued on the first IDLE edge):
- Two full transfers.
- cpu_rdy=1 for exactly one cycle between them.
